// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU:
//   - ALU operation codes (4-bit)
//   - FSM state enum (IDLE / RUN / DONE)
//   - is_arith(): classifies an op code as arithmetic (anything that is not
//     AND, OR or NOR goes through the adder path)
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unknown codes are deliberately arithmetic: op[3]/op[2] then select
  // operand inversion and op[2] doubles as the carry-in.
  function automatic logic is_arith(input logic [3:0] op);
    return !((op == ALU_AND) || (op == ALU_OR) || (op == ALU_NOR));
  endfunction

endpackage

// File: rtl/alu_slice.sv
// ---------------------------------------------------------------------------
// alu_slice
// Combinational 1-bit ALU slice. Operand inversion is applied by the caller,
// so ai/bi arrive already conditioned by op[3]/op[2].
// Ports:
//   ai, bi : conditioned operand bits
//   cin    : carry into this bit (arithmetic ops)
//   op     : 4-bit ALU op code
//   sum    : result bit (logic result for AND/OR/NOR, sum bit otherwise)
//   cout   : majority carry out (only meaningful for arithmetic ops)
// ---------------------------------------------------------------------------
module alu_slice
  import alu_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       sum,
  output logic       cout
);

  always_comb begin
    sum  = ai ^ bi ^ cin;
    cout = (ai & bi) | (ai & cin) | (bi & cin);
    if (op == ALU_OR) begin
      sum = ai | bi;
    end else if (!is_arith(op)) begin
      // AND, and NOR as ~a & ~b (both operands already inverted)
      sum = ai & bi;
    end
  end

endmodule

// File: rtl/bit_serial_alu.sv
// ---------------------------------------------------------------------------
// bit_serial_alu
// Multi-cycle bit-serial ALU. Operands and op are latched on start in IDLE,
// then one bit per cycle is pushed through a single alu_slice, LSB first,
// with the carry kept in a register between bits. After WIDTH bits the
// assembled result and flags are registered and done pulses for one cycle.
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   CNT_W : bit counter width
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : request, sampled only in IDLE
//   alu_op    : op code, latched with start
//   a, b      : operands, latched with start
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse, result/flags valid
//   result    : final result, held until replaced by the next operation
//   zero      : result == 0
//   carry_out : carry out of MSB for arithmetic ops, else 0
//   overflow  : (only with BIT_SERIAL_ALU_OVF_EN defined) carry into MSB XOR
//               carry out of MSB for arithmetic ops, else 0
// Optional feature macro: BIT_SERIAL_ALU_OVF_EN
// ---------------------------------------------------------------------------
module bit_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef BIT_SERIAL_ALU_OVF_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic slice_ai, slice_bi, slice_sum, slice_cout;
  logic arith;

  // Operand registers shift right each RUN cycle, so bit 0 is always the
  // bit currently being processed.
  assign arith    = is_arith(op_q);
  assign slice_ai = op_q[3] ? ~a_q[0] : a_q[0];
  assign slice_bi = op_q[2] ? ~b_q[0] : b_q[0];

  alu_slice u_slice (
    .ai   (slice_ai),
    .bi   (slice_bi),
    .cin  (carry_q),
    .op   (op_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = alu_op;
          cnt_d   = '0;
          carry_d = is_arith(alu_op) ? alu_op[2] : 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {slice_sum, sh_q[WIDTH-1:1]};
        carry_d = arith ? slice_cout : 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          // Flags come from the fully assembled word, including this bit.
          result_d = sh_d;
          zero_d   = (sh_d == '0);
          cout_d   = arith ? slice_cout : 1'b0;
          // carry_q here is the carry into the MSB.
          ovf_d    = arith ? (carry_q ^ slice_cout) : 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;

`ifdef BIT_SERIAL_ALU_OVF_EN
  assign overflow = ovf_q;
`else
  // Overflow tracking has no output in this build.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_alu
// Directed self-checking bench for bit_serial_alu (WIDTH = 8). Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bit_serial_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alu_op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, carry_out;
  logic [W-1:0] result;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic         overflow;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
`ifdef BIT_SERIAL_ALU_OVF_EN
    .overflow  (overflow),
`endif
    .carry_out (carry_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done, starting from cycle count cyc, then check
  // latency, result and flags, and that done drops after one cycle.
  task automatic finish_op(input string tag, input int cyc_in,
                           input logic [7:0] exp_res, input logic exp_z,
                           input logic exp_c, input logic exp_v);
    int cyc;
    cyc = cyc_in;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/done"},    16'(done), 16'd1);
    chk({tag, "/latency"}, 16'(cyc), 16'd9);
    chk({tag, "/result"},  16'(result), 16'(exp_res));
    chk({tag, "/zero"},    16'(zero), 16'(exp_z));
    chk({tag, "/carry"},   16'(carry_out), 16'(exp_c));
`ifdef BIT_SERIAL_ALU_OVF_EN
    chk({tag, "/ovf"},     16'(overflow), 16'(exp_v));
`endif
    $display("op %s: result=0x%02h zero=%0b carry_out=%0b latency=%0d (exp result=0x%02h v=%0b)",
             tag, result, zero, carry_out, cyc, exp_res, exp_v);
    @(negedge clk);
    chk({tag, "/done_pulse"}, 16'(done), 16'd0);
    chk({tag, "/idle"},       16'(busy), 16'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_res, input logic exp_z,
                        input logic exp_c, input logic exp_v);
    alu_op = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/busy"}, 16'(busy), 16'd1);
    finish_op(tag, 1, exp_res, exp_z, exp_c, exp_v);
  endtask

  initial begin
    int cyc;
    reset  = 1'b0;
    start  = 1'b0;
    alu_op = 4'h0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst/busy",   16'(busy), 16'd0);
    chk("rst/done",   16'(done), 16'd0);
    chk("rst/result", 16'(result), 16'h00);
    chk("rst/zero",   16'(zero), 16'd0);
    chk("rst/carry",  16'(carry_out), 16'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("add_7f_01", ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("sub_05_05", ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("and_f0_3c", ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("or_f0_0f",  ALU_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("nor_0f_f0", ALU_NOR, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("nor_00_00", ALU_NOR, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01", ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    // op 1000: ~A + B with carry-in 0 -> 0xFA + 0x10 = 0x10A
    run_op("op8_05_10", 4'b1000, 8'h05, 8'h10, 8'h0A, 1'b0, 1'b1, 1'b0);

    // Start while busy is ignored; operand changes mid-run have no effect.
    alu_op = ALU_ADD;
    a      = 8'h10;
    b      = 8'h20;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    @(negedge clk);
    cyc = 2;
    alu_op = ALU_SUB;
    a      = 8'hFF;
    b      = 8'h01;
    start  = 1'b1;
    @(negedge clk);
    cyc   = 3;
    start = 1'b0;
    alu_op = ALU_AND;
    a      = 8'h00;
    b      = 8'h00;
    finish_op("add_10_20_ign", cyc, 8'h30, 1'b0, 1'b0, 1'b0);
    // Back-to-back: start in the IDLE cycle right after DONE.
    run_op("sub_30_31_b2b", ALU_SUB, 8'h30, 8'h31, 8'hFF, 1'b0, 1'b0, 1'b0);

    // Leave nonzero result and carry set before the reset test.
    run_op("add_ff_81", ALU_ADD, 8'hFF, 8'h81, 8'h80, 1'b0, 1'b1, 1'b0);

    // Reset mid-operation
    alu_op = ALU_ADD;
    a      = 8'h40;
    b      = 8'h40;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst/busy",   16'(busy), 16'd0);
    chk("midrst/done",   16'(done), 16'd0);
    chk("midrst/result", 16'(result), 16'h00);
    chk("midrst/zero",   16'(zero), 16'd0);
    chk("midrst/carry",  16'(carry_out), 16'd0);
`ifdef BIT_SERIAL_ALU_OVF_EN
    chk("midrst/ovf",    16'(overflow), 16'd0);
`endif
    $display("reset mid-op: busy=%0b done=%0b result=0x%02h", busy, done, result);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("add_01_02_post", ALU_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
